// File: rtl/pe_scatter_pkg.sv
// Shared types and sizing for the serial-to-lane scatter block.
// Lane/width defaults follow the PE array build configuration.
`ifndef N_PE
`define N_PE 32
`endif
`ifndef WID_PE_BITS
`define WID_PE_BITS 16
`endif

package pe_scatter_pkg;

    localparam int N_PE_DEF   = `N_PE;
    localparam int WID_PE_DEF = `WID_PE_BITS;
    localparam int LANE_IDX_W = $clog2(N_PE_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STALL = 2'd2
    } scat_state_t;

    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 1) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/pe_scatter_lane_dec.sv
// Fill index to one-hot lane write enable; the same vector sets buffer lanes and mask bits.
// Combinational, zero latency; no backpressure of its own.
module lane_onehot_dec #(
    parameter int N_LANES = 32,
    parameter int IDX_W   = 5
) (
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [N_LANES-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (idx == IDX_W'(i)) onehot[i] = en;
        end
    end

endmodule

// File: rtl/pe_scatter.sv
// Assembles serial words into a packed lane vector plus mask, with a single-cycle broadcast mode.
// Latency: output valid the cycle after the completing handshake; in_ready drops only while a finished vector waits behind a busy output.
module pe_scatter
    import pe_scatter_pkg::*;
#(
    parameter int N_LANES = N_PE_DEF,
    parameter int WIDTH   = WID_PE_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_last,
    input  logic                         in_bcast,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH*N_LANES-1:0]     out_data_packed,
    output logic [N_LANES-1:0]           out_mask,
    output logic [$clog2(N_LANES+1)-1:0] fill_count
);

    localparam int FCW = $clog2(N_LANES + 1);
    localparam int LIW = lane_idx_w(N_LANES);
    localparam int VW  = WIDTH * N_LANES;

    scat_state_t        state, state_nxt;
    logic [VW-1:0]      asm_data, asm_data_nxt;
    logic [N_LANES-1:0] asm_mask, asm_mask_nxt, lane_we;
    logic               accept, bcast_ok, complete, slot_free, drain;
    logic               load_in, load_asm;

    assign accept    = in_valid && in_ready;
    assign bcast_ok  = in_bcast && (fill_count == '0);
    assign complete  = accept && (in_last || in_bcast || fill_count == FCW'(N_LANES - 1));
    assign slot_free = !out_valid || out_ready;
    assign drain     = out_valid && out_ready;

    // fill_count only reaches N_LANES in STALL, where accept is low, so the truncated index is safe
    lane_onehot_dec #(
        .N_LANES (N_LANES),
        .IDX_W   (LIW)
    ) u_dec (
        .idx    (fill_count[LIW-1:0]),
        .en     (accept),
        .onehot (lane_we)
    );

    always_comb begin
        asm_data_nxt = asm_data;
        asm_mask_nxt = asm_mask | lane_we;
        for (int i = 0; i < N_LANES; i++) begin
            if (lane_we[i]) asm_data_nxt[i*WIDTH +: WIDTH] = in_data;
        end
        // A late broadcast falls through as an appended last word
        if (accept && bcast_ok) begin
            asm_data_nxt = {N_LANES{in_data}};
            asm_mask_nxt = '1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt != STALL);
        end
    end

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_asm  = 1'b0;
        case (state)
            IDLE, FILL: begin
                if (complete) begin
                    if (slot_free) begin
                        load_in   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STALL;
                    end
                end else if (accept) begin
                    state_nxt = FILL;
                end
            end
            STALL: begin
                if (drain) begin
                    load_asm  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_data        <= '0;
            asm_mask        <= '0;
            fill_count      <= '0;
            out_valid       <= 1'b0;
            out_data_packed <= '0;
            out_mask        <= '0;
        end else if (load_in) begin
            out_data_packed <= asm_data_nxt;
            out_mask        <= asm_mask_nxt;
            out_valid       <= 1'b1;
            asm_data        <= '0;
            asm_mask        <= '0;
            fill_count      <= '0;
        end else if (load_asm) begin
            out_data_packed <= asm_data;
            out_mask        <= asm_mask;
            out_valid       <= 1'b1;
            asm_data        <= '0;
            asm_mask        <= '0;
            fill_count      <= '0;
        end else begin
            if (drain) out_valid <= 1'b0;
            if (accept) begin
                asm_data   <= asm_data_nxt;
                asm_mask   <= asm_mask_nxt;
                fill_count <= bcast_ok ? FCW'(N_LANES) : fill_count + FCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_scatter.sv
module tb_pe_scatter;

    localparam int N  = 32;
    localparam int W  = 16;
    localparam int VW = N * W;

    typedef struct {
        logic [VW-1:0] d;
        logic [N-1:0]  m;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last, in_bcast;
    logic [W-1:0]  in_data;
    logic          out_valid, out_ready;
    logic [VW-1:0] out_data_packed;
    logic [N-1:0]  out_mask;
    logic [5:0]    fill_count;

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t sbq[$];

    logic [VW-1:0] m_d;
    logic [N-1:0]  m_m;
    int            m_cnt;

    logic          hold_v = 1'b0;
    logic [VW-1:0] hold_d;
    logic [N-1:0]  hold_m;

    pe_scatter #(.N_LANES(N), .WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_bcast        (in_bcast),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data_packed (out_data_packed),
        .out_mask        (out_mask),
        .fill_count      (fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_d   = '0;
        m_m   = '0;
        m_cnt = 0;
    endtask

    task automatic push_vec(input logic [VW-1:0] d, input logic [N-1:0] m);
        vec_t v;
        v.d = d;
        v.m = m;
        sbq.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted
    task automatic send(input logic [W-1:0] d, input logic l, input logic b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bcast = b;
        while (!in_ready) begin
            if (guard >= 100) begin
                vectors++;
                miscompares++;
                $error("FAIL in_ready_timeout: got 0 expected 1");
                in_valid = 1'b0;
                in_last  = 1'b0;
                in_bcast = 1'b0;
                return;
            end
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bcast = 1'b0;
        if (b && m_cnt == 0) begin
            push_vec({N{d}}, '1);
        end else begin
            m_d[m_cnt*W +: W] = d;
            m_m[m_cnt]        = 1'b1;
            m_cnt++;
            if (m_cnt == N || l || b) begin
                push_vec(m_d, m_m);
                model_clear();
            end
        end
    endtask

    task automatic send_seq(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + W'(i), 1'b0, 1'b0);
    endtask

    // Output monitor: scoreboard pop on handshake, stability while stalled
    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", VW'(out_valid), VW'(1));
                chk("hold_data", out_data_packed, hold_d);
                chk("hold_mask", VW'(out_mask), VW'(hold_m));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_vector", VW'(out_valid), VW'(0));
                end else begin
                    vec_t e;
                    e = sbq.pop_front();
                    chk("vec_data", out_data_packed, e.d);
                    chk("vec_mask", VW'(out_mask), VW'(e.m));
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data_packed;
            hold_m = out_mask;
        end
    end

    initial begin
        longint t0;
        int guard;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bcast  = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        chk("rst_out_data", out_data_packed, VW'(0));
        chk("rst_out_mask", VW'(out_mask), VW'(0));
        chk("rst_fill", VW'(fill_count), VW'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", VW'(in_ready), VW'(1));

        // Full vector, out_valid exactly one cycle after word 32
        out_ready = 1'b1;
        send_seq(16'h0001, 31);
        chk("full_pre_valid", VW'(out_valid), VW'(0));
        chk("full_fill31", VW'(fill_count), VW'(31));
        send(16'h0020, 1'b0, 1'b0);
        chk("full_latency", VW'(out_valid), VW'(1));
        chk("full_fill0", VW'(fill_count), VW'(0));
        @(negedge clk);

        // Early close with in_last
        send_seq(16'hA000, 5);
        send(16'hA005, 1'b1, 1'b0);
        chk("last_valid", VW'(out_valid), VW'(1));
        chk("last_mask_direct", VW'(out_mask), VW'(32'h0000_003F));
        @(negedge clk);

        // Broadcast from empty buffer
        send(16'h7FFF, 1'b0, 1'b1);
        chk("bcast_valid", VW'(out_valid), VW'(1));
        @(negedge clk);

        // Late broadcast acts as an appended last word
        send_seq(16'h0B00, 3);
        send(16'hBEEF, 1'b0, 1'b1);
        chk("late_bcast_mask", VW'(out_mask), VW'(32'h0000_000F));
        @(negedge clk);

        // Two vectors against a blocked output
        out_ready = 1'b0;
        send_seq(16'h1000, 64);
        chk("stall_in_ready", VW'(in_ready), VW'(0));
        chk("stall_fill", VW'(fill_count), VW'(32));
        chk("stall_out_valid", VW'(out_valid), VW'(1));
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("unstall_v2_valid", VW'(out_valid), VW'(1));
        chk("unstall_in_ready", VW'(in_ready), VW'(1));
        chk("unstall_fill", VW'(fill_count), VW'(0));
        @(negedge clk);
        chk("unstall_drained", VW'(out_valid), VW'(0));

        // Back-to-back drain/refill: 3 broadcasts then a full vector, no bubbles
        t0 = $time;
        send(16'h1111, 1'b0, 1'b1);
        chk("b2b_v1", VW'(out_valid), VW'(1));
        send(16'h2222, 1'b0, 1'b1);
        chk("b2b_v2", VW'(out_valid), VW'(1));
        send(16'h3333, 1'b0, 1'b1);
        chk("b2b_v3", VW'(out_valid), VW'(1));
        send_seq(16'h4000, 32);
        chk("b2b_cycles", VW'($time - t0), VW'(35 * 10));
        @(negedge clk);

        // Reset with a pending output and a partial assembly
        out_ready = 1'b0;
        send_seq(16'h5000, 32);
        send_seq(16'h6000, 10);
        rst = 1'b0;
        sbq.delete();
        model_clear();
        #1;
        chk("mid_rst_valid", VW'(out_valid), VW'(0));
        chk("mid_rst_data", out_data_packed, VW'(0));
        chk("mid_rst_mask", VW'(out_mask), VW'(0));
        chk("mid_rst_fill", VW'(fill_count), VW'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", VW'(in_ready), VW'(1));
        chk("post_rst_no_pulse", VW'(out_valid), VW'(0));
        out_ready = 1'b1;
        send_seq(16'h0100, 32);

        guard = 0;
        while (sbq.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("sb_empty", VW'(sbq.size()), VW'(0));
        @(negedge clk);
        chk("final_idle", VW'(out_valid), VW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
